// File: rtl/expr_arb_pkg.sv
// Shared types for the expression-unit arbiter: requester id width and tag-line entry.
package expr_arb_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = $clog2(NREQ);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a registered pointer.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;
    int unsigned    idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!found && req[IDW'(idx)]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
        if (en && found) begin
            grant[grant_id] = 1'b1;
        end

        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (32'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/expr_pipe_arbiter.sv
// Shares one pipelined expression unit among N requesters; a tag line matched to the
// unit latency steers each result back to the requester that issued it.
module expr_pipe_arbiter
    import expr_arb_pkg::*;
#(
    parameter int unsigned N       = NREQ,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RES_DLY = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WIDTH-1:0]   req_a,
    input  logic [N*WIDTH-1:0]   req_b,
    input  logic [N*WIDTH-1:0]   req_c,
    input  logic [N*WIDTH-1:0]   req_d,
    output logic                 eu_valid_in,
    output logic [WIDTH-1:0]     eu_a,
    output logic [WIDTH-1:0]     eu_b,
    output logic [WIDTH-1:0]     eu_c,
    output logic [WIDTH-1:0]     eu_d,
    input  logic [2*WIDTH-1:0]   eu_q,
    output logic [N-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]   rsp_q,
    output logic                 busy
);

    logic [N-1:0]       grant;
    logic [IDW-1:0]     grant_id;
    logic               accept;

    logic               issue_vld_q, issue_vld_d;
    logic [IDW-1:0]     issue_id_q, issue_id_d;
    logic [WIDTH-1:0]   eu_a_q, eu_a_d, eu_b_q, eu_b_d, eu_c_q, eu_c_d, eu_d_q, eu_d_d;

    tag_t               issue_tag;
    tag_t               tag_out;
    tag_t [RES_DLY-1:0] tag_q, tag_d;
    logic               tag_busy;

    logic [N-1:0]       rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0] rsp_q_q, rsp_q_d;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_comb begin
        issue_vld_d = accept;
        issue_id_d  = issue_id_q;
        eu_a_d      = eu_a_q;
        eu_b_d      = eu_b_q;
        eu_c_d      = eu_c_q;
        eu_d_d      = eu_d_q;
        if (accept) begin
            issue_id_d = grant_id;
            for (int unsigned i = 0; i < N; i++) begin
                if (grant[i]) begin
                    eu_a_d = req_a[i*WIDTH +: WIDTH];
                    eu_b_d = req_b[i*WIDTH +: WIDTH];
                    eu_c_d = req_c[i*WIDTH +: WIDTH];
                    eu_d_d = req_d[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // The tag enters the line from the issue register, so its exit lines up with
    // eu_q RES_DLY cycles after eu_valid_in.
    always_comb begin
        issue_tag     = '0;
        issue_tag.vld = issue_vld_q;
        issue_tag.id  = issue_id_q;
        tag_d         = {tag_q[RES_DLY-2:0], issue_tag};
        tag_out       = tag_q[RES_DLY-1];
        tag_busy      = 1'b0;
        for (int unsigned i = 0; i < RES_DLY; i++) begin
            tag_busy = tag_busy | tag_q[i].vld;
        end

        rsp_valid_d = '0;
        rsp_q_d     = rsp_q_q;
        if (tag_out.vld) begin
            rsp_valid_d[tag_out.id] = 1'b1;
            rsp_q_d                 = eu_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_vld_q <= 1'b0;
            issue_id_q  <= '0;
            eu_a_q      <= '0;
            eu_b_q      <= '0;
            eu_c_q      <= '0;
            eu_d_q      <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_q_q     <= '0;
        end else begin
            issue_vld_q <= issue_vld_d;
            issue_id_q  <= issue_id_d;
            eu_a_q      <= eu_a_d;
            eu_b_q      <= eu_b_d;
            eu_c_q      <= eu_c_d;
            eu_d_q      <= eu_d_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
        end
    end

    assign eu_valid_in = issue_vld_q;
    assign eu_a        = eu_a_q;
    assign eu_b        = eu_b_q;
    assign eu_c        = eu_c_q;
    assign eu_d        = eu_d_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_q       = rsp_q_q;

    // The response register counts as in flight, so busy drops the cycle after the last pulse.
    assign busy = issue_vld_q | tag_busy | (|rsp_valid_q);

endmodule
